// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transmit arbiter and its transmitter.
// Holds the arbiter state encoding and a one-hot to index helper.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 8;
    localparam int SPI_NUM_REQ    = 4;
    localparam int SPI_GAP_CYCLES = 4;
    localparam int SPI_MAX_REQ    = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } arb_state_t;

    // Returns the index of the set bit; the vector is sized for the largest requester count.
    function automatic logic [2:0] onehot_to_idx(input logic [SPI_MAX_REQ-1:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < SPI_MAX_REQ; i++) begin
            if (onehot[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/spi_tx_arbiter_rr_priority_picker.sv
// Combinational rotating-priority picker: first set request at or above ptr, with wrap.
// Tying ptr to zero turns it into a plain lowest-index-wins priority encoder.
module rr_priority_picker
    import spi_pkg::*;
#(
    parameter int P_NUM_REQ = SPI_NUM_REQ
)(
    input  logic [P_NUM_REQ-1:0]         req,
    input  logic [$clog2(P_NUM_REQ)-1:0] ptr,
    output logic [$clog2(P_NUM_REQ)-1:0] winner,
    output logic                         found
);

    localparam int IW = $clog2(P_NUM_REQ);

    logic [P_NUM_REQ-1:0] grant_oh;
    logic [IW:0]          pos_ext;
    logic [IW-1:0]        pos;

    // Walk the requests starting at ptr; pos_ext carries one spare bit so the wrap is a subtract.
    always_comb begin
        grant_oh = '0;
        found    = 1'b0;
        pos_ext  = '0;
        pos      = '0;
        for (int k = 0; k < P_NUM_REQ; k++) begin
            pos_ext = {1'b0, ptr} + (IW+1)'(k);
            if (pos_ext >= (IW+1)'(P_NUM_REQ)) begin
                pos_ext = pos_ext - (IW+1)'(P_NUM_REQ);
            end
            pos = pos_ext[IW-1:0];
            if (!found && req[pos]) begin
                grant_oh[pos] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    assign winner = IW'(onehot_to_idx(SPI_MAX_REQ'(grant_oh)));

endmodule

// File: rtl/spi_tx_arbiter.sv
// Shares one SPI master transmitter between several requesters, one whole burst at a time.
// Define SPI_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module spi_tx_arbiter
    import spi_pkg::*;
#(
    parameter int P_DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int P_NUM_REQ    = SPI_NUM_REQ,
    parameter int P_GAP_CYCLES = SPI_GAP_CYCLES
)(
    input  logic                              clk_100,
    input  logic                              s_rst,
    input  logic [P_NUM_REQ-1:0]              req_valid,
    input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] req_data,
    input  logic [P_NUM_REQ-1:0]              req_last,
    output logic [P_NUM_REQ-1:0]              req_ready,
    output logic                              tx_valid,
    output logic [P_DATA_WIDTH-1:0]           tx_data,
    input  logic                              tx_ready,
    output logic [P_NUM_REQ-1:0]              cs_sel,
    output logic [$clog2(P_NUM_REQ)-1:0]      grant_id,
    output logic                              arb_busy
);

    localparam int IW = $clog2(P_NUM_REQ);

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        rr_ptr_nxt;
    logic [IW-1:0]        grant_nxt;
    logic [IW-1:0]        pick_ptr;
    logic [IW-1:0]        pick_idx;
    logic                 pick_found;
    logic [P_NUM_REQ-1:0] cs_nxt;
    logic                 last_q;
    logic                 last_nxt;
    logic [7:0]           gap_cnt;
    logic [7:0]           gap_nxt;

`ifdef SPI_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    assign pick_ptr = rr_ptr;
`endif

    rr_priority_picker #(
        .P_NUM_REQ (P_NUM_REQ)
    ) u_picker (
        .req    (req_valid),
        .ptr    (pick_ptr),
        .winner (pick_idx),
        .found  (pick_found)
    );

    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            cs_sel   <= '0;
            last_q   <= 1'b0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant_id <= grant_nxt;
            cs_sel   <= cs_nxt;
            last_q   <= last_nxt;
            gap_cnt  <= gap_nxt;
        end
    end

    // The handshake outputs exist only in LOAD, so every other state presents zeros to both sides.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant_id;
        cs_nxt     = cs_sel;
        last_nxt   = last_q;
        gap_nxt    = gap_cnt;
        tx_valid   = 1'b0;
        tx_data    = '0;
        req_ready  = '0;

        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_nxt = ARB;
                end
            end

            ARB: begin
                cs_nxt = '0;
                if (pick_found) begin
                    grant_nxt        = pick_idx;
                    cs_nxt[pick_idx] = 1'b1;
                    state_nxt        = LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end

            LOAD: begin
                tx_valid            = req_valid[grant_id];
                req_ready[grant_id] = tx_ready;
                for (int i = 0; i < P_NUM_REQ; i++) begin
                    if (grant_id == IW'(i)) begin
                        tx_data = req_data[i*P_DATA_WIDTH +: P_DATA_WIDTH];
                    end
                end
                if (req_valid[grant_id] && tx_ready) begin
                    last_nxt  = req_last[grant_id];
                    state_nxt = WAIT_BUSY;
                end
            end

            // Ready dropping proves the transmitter took the word before we look for completion.
            WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_nxt = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                if (tx_ready) begin
                    if (last_q) begin
                        state_nxt = GAP;
                        cs_nxt    = '0;
                        gap_nxt   = '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
                        rr_ptr_nxt = (grant_id == IW'(P_NUM_REQ-1)) ? '0 : grant_id + 1'b1;
`endif
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end

            GAP: begin
                if (gap_cnt == 8'(P_GAP_CYCLES-1)) begin
                    gap_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt + 8'd1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign arb_busy = (state != IDLE);

endmodule
